// File: rtl/module_counter_pkg.sv
// -----------------------------------------------------------------------------
// module_counter_pkg
// Shared definitions for the counter family (up-counter / countdown timer).
//   DEFAULT_WIDTH : default counter width
//   ST_IDLE/ST_RUN/ST_DONE : FSM state encodings
//   is_loadable() : 1 when a state accepts a new load
// -----------------------------------------------------------------------------
package module_counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_loadable(input state_t st);
    return (st == ST_IDLE) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/module_countdown_8_bit_if.sv
// -----------------------------------------------------------------------------
// module_countdown_8_bit_if
// Control / status bundle of the countdown timer.
//   load_valid, load_value, load_ready : load handshake
//   reload_en, active, abort           : run control
//   out, borrow, busy, done            : registered status
// master = controller side, slave = timer side.
// -----------------------------------------------------------------------------
interface module_countdown_8_bit_if #(
  parameter int WIDTH = module_counter_pkg::DEFAULT_WIDTH
);
  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;
  logic             reload_en;
  logic             active;
  logic             abort;
  logic [WIDTH-1:0] out;
  logic             borrow;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_value, reload_en, active, abort,
    input  load_ready, out, borrow, busy, done
  );

  modport slave (
    input  load_valid, load_value, reload_en, active, abort,
    output load_ready, out, borrow, busy, done
  );
endinterface

// File: rtl/module_countdown_8_bit_prescaler.sv
// -----------------------------------------------------------------------------
// module_prescaler
// Divides enabled cycles by PRESCALE; tick is high on the enabled cycle that
// completes a group of PRESCALE enabled cycles.
//   clk_in, rst_in : clock, async active-high reset
//   clear          : synchronous return of the count to 0 (wins over enable)
//   enable         : count this cycle; the count holds while low
//   tick           : combinational, enable && count == PRESCALE-1
// -----------------------------------------------------------------------------
module module_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_reg;

  // With PRESCALE==1 LAST is 0 and the count never leaves 0, so tick == enable.
  assign tick = enable && (count_reg == LAST);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= tick ? '0 : count_reg + CW'(1);
    end
  end
endmodule

// File: rtl/module_countdown_8_bit.sv
// -----------------------------------------------------------------------------
// module_countdown_8_bit
// Loadable modulo down-counter / timer with optional auto-reload.
//   clk_in : clock
//   rst_in : async active-high reset
//   bus    : slave side of module_countdown_8_bit_if
//            (load handshake, reload_en/active/abort, out/borrow/busy/done)
// A loaded value counts down on prescaled active ticks; reaching terminal
// count emits a one-cycle borrow and either reloads or stops in DONE.
// -----------------------------------------------------------------------------
module module_countdown_8_bit
  import module_counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  module_countdown_8_bit_if.slave bus
);
  state_t           state_reg;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] reload_reg;
  logic             borrow_reg;
  logic             busy_reg;
  logic             done_reg;

  logic running;
  logic load_fire;
  logic pre_clear;
  logic pre_enable;
  logic tick;

  assign running   = (state_reg == ST_RUN);
  assign load_fire = is_loadable(state_reg) && bus.load_valid;

  // Abort outranks counting, so it also keeps the prescaler from advancing.
  assign pre_clear  = load_fire || (running && bus.abort);
  assign pre_enable = running && bus.active && !bus.abort;

  module_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (pre_clear),
    .enable (pre_enable),
    .tick   (tick)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg  <= ST_IDLE;
      out_reg    <= '0;
      reload_reg <= '0;
      borrow_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      borrow_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (bus.load_valid) begin
            out_reg    <= bus.load_value;
            reload_reg <= bus.load_value;
            if (bus.load_value != '0) begin
              state_reg <= ST_RUN;
              busy_reg  <= 1'b1;
              done_reg  <= 1'b0;
            end else begin
              // A zero load is already at terminal count.
              state_reg  <= ST_DONE;
              borrow_reg <= 1'b1;
              busy_reg   <= 1'b0;
              done_reg   <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state_reg <= ST_IDLE;
            out_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end else if (tick) begin
            if (out_reg > WIDTH'(1)) begin
              out_reg <= out_reg - WIDTH'(1);
            end else begin
              // Terminal count; the <=1 test keeps out from wrapping below 0.
              borrow_reg <= 1'b1;
              if (bus.reload_en) begin
                out_reg <= reload_reg;
              end else begin
                out_reg   <= '0;
                state_reg <= ST_DONE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          out_reg   <= '0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out        = out_reg;
  assign bus.borrow     = borrow_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.load_ready = is_loadable(state_reg);
endmodule

// File: tb/tb_module_countdown_8_bit.sv
// -----------------------------------------------------------------------------
// tb_module_countdown_8_bit
// Scoreboard bench for module_countdown_8_bit: dut1 uses PRESCALE=1, dut4 uses
// PRESCALE=4. Expected per-cycle samples {out, borrow, busy, done, load_ready}
// are queued when stimulus is set up and popped one per clock.
// -----------------------------------------------------------------------------
module tb_module_countdown_8_bit;

  typedef struct packed {
    logic [7:0] out;
    logic       borrow;
    logic       busy;
    logic       done;
    logic       ready;
  } smp_t;

  logic clk;
  logic rst;
  smp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  module_countdown_8_bit_if #(.WIDTH(8)) b1 ();
  module_countdown_8_bit_if #(.WIDTH(8)) b4 ();

  module_countdown_8_bit #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (b1)
  );

  module_countdown_8_bit #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic smp_t mk(input int o, input bit b, input bit bz, input bit d, input bit r);
    smp_t s;
    s.out    = 8'(o);
    s.borrow = b;
    s.busy   = bz;
    s.done   = d;
    s.ready  = r;
    return s;
  endfunction

  function automatic smp_t obs1();
    smp_t s;
    s.out    = b1.out;
    s.borrow = b1.borrow;
    s.busy   = b1.busy;
    s.done   = b1.done;
    s.ready  = b1.load_ready;
    return s;
  endfunction

  function automatic smp_t obs4();
    smp_t s;
    s.out    = b4.out;
    s.borrow = b4.borrow;
    s.busy   = b4.busy;
    s.done   = b4.done;
    s.ready  = b4.load_ready;
    return s;
  endfunction

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    smp_t o;
    #2;
    o = obs1();
    checks++;
    if (o !== mk(0, 0, 0, 0, 1)) begin
      errors++;
      $display("FAIL reset_dut1: got out=%0d flags=%b, expected out=0 flags=0001", o.out, o[3:0]);
    end
    o = obs4();
    checks++;
    if (o !== mk(0, 0, 0, 0, 1)) begin
      errors++;
      $display("FAIL reset_dut4: got out=%0d flags=%b, expected out=0 flags=0001", o.out, o[3:0]);
    end
    $display("reset applied: dut1 out=%0d dut4 out=%0d", b1.out, b4.out);
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_count();
    smp_t e, o;
    int   cyc = 0;
    b1.load_value = 8'd50; b1.load_valid = 1'b1; b1.active = 1'b1; b1.reload_en = 1'b0;
    for (int i = 0; i < 10; i++) sb.push_back(mk(50 - i, 0, 1, 0, 0));
    while (sb.size() > 0) begin
      step();
      b1.load_valid = 1'b0;
      e = sb.pop_front();
      o = obs1();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid_count cyc%0d: got out=%0d flags=%b, expected out=%0d flags=%b",
                 cyc, o.out, o[3:0], e.out, e[3:0]);
      end
      cyc++;
    end
    // Assert reset between edges; outputs must clear without waiting for a clock.
    #2 rst = 1'b1;
    #1;
    o = obs1();
    checks++;
    if (o !== mk(0, 0, 0, 0, 1)) begin
      errors++;
      $display("FAIL reset_async: got out=%0d flags=%b, expected out=0 flags=0001", o.out, o[3:0]);
    end
    $display("load 50 on dut1, async reset after 10 cycles: out=%0d", b1.out);
    #1 rst = 1'b0;
    step();
  endtask

  task automatic test_count_down();
    smp_t e, o;
    int   cyc = 0;
    b1.load_value = 8'd5; b1.load_valid = 1'b1; b1.active = 1'b1; b1.reload_en = 1'b0;
    for (int v = 5; v >= 1; v--) sb.push_back(mk(v, 0, 1, 0, 0));
    sb.push_back(mk(0, 1, 0, 1, 1));
    sb.push_back(mk(0, 0, 0, 1, 1));
    while (sb.size() > 0) begin
      step();
      b1.load_valid = 1'b0;
      e = sb.pop_front();
      o = obs1();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL count_down cyc%0d: got out=%0d flags=%b, expected out=%0d flags=%b",
                 cyc, o.out, o[3:0], e.out, e[3:0]);
      end
      cyc++;
    end
    $display("load 5 on dut1, one-shot: final out=%0d done=%0b", b1.out, b1.done);
  endtask

  task automatic test_reload_abort();
    smp_t e, o;
    int   cyc = 0;
    b1.load_value = 8'd3; b1.load_valid = 1'b1; b1.active = 1'b1; b1.reload_en = 1'b1;
    for (int i = 0; i < 9; i++) sb.push_back(mk(3 - (i % 3), (i > 0) && (i % 3 == 0), 1, 0, 0));
    // Abort on the cycle that would otherwise hit terminal count: no borrow.
    sb.push_back(mk(0, 0, 0, 0, 1));
    while (sb.size() > 0) begin
      step();
      b1.load_valid = 1'b0;
      b1.abort = (cyc == 8);
      e = sb.pop_front();
      o = obs1();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reload_abort cyc%0d: got out=%0d flags=%b, expected out=%0d flags=%b",
                 cyc, o.out, o[3:0], e.out, e[3:0]);
      end
      cyc++;
    end
    b1.abort = 1'b0;
    b1.reload_en = 1'b0;
    $display("load 3 on dut1 with reload, aborted: out=%0d busy=%0b", b1.out, b1.busy);
  endtask

  task automatic test_zero_and_max();
    smp_t e, o;
    int   cyc = 0;
    b1.load_value = 8'd0; b1.load_valid = 1'b1; b1.active = 1'b1;
    sb.push_back(mk(0, 1, 0, 1, 1));
    sb.push_back(mk(0, 0, 0, 1, 1));
    while (sb.size() > 0) begin
      step();
      b1.load_valid = 1'b0;
      e = sb.pop_front();
      o = obs1();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL zero_load cyc%0d: got out=%0d flags=%b, expected out=%0d flags=%b",
                 cyc, o.out, o[3:0], e.out, e[3:0]);
      end
      cyc++;
    end
    $display("load 0 on dut1: done=%0b", b1.done);
    cyc = 0;
    b1.load_value = 8'd255; b1.load_valid = 1'b1;
    for (int i = 0; i < 255; i++) sb.push_back(mk(255 - i, 0, 1, 0, 0));
    sb.push_back(mk(0, 1, 0, 1, 1));
    sb.push_back(mk(0, 0, 0, 1, 1));
    while (sb.size() > 0) begin
      step();
      b1.load_valid = 1'b0;
      e = sb.pop_front();
      o = obs1();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL max_load cyc%0d: got out=%0d flags=%b, expected out=%0d flags=%b",
                 cyc, o.out, o[3:0], e.out, e[3:0]);
      end
      cyc++;
    end
    $display("load 255 on dut1: final out=%0d done=%0b", b1.out, b1.done);
  endtask

  task automatic test_hold_load();
    smp_t e, o;
    int   cyc = 0;
    b1.load_value = 8'd4; b1.load_valid = 1'b1; b1.active = 1'b1;
    for (int v = 4; v >= 1; v--) sb.push_back(mk(v, 0, 1, 0, 0));
    sb.push_back(mk(0, 1, 0, 1, 1));
    // load_valid still high with value 9: taken on the first DONE cycle.
    sb.push_back(mk(9, 0, 1, 0, 0));
    sb.push_back(mk(0, 0, 0, 0, 1));
    while (sb.size() > 0) begin
      step();
      b1.load_value = 8'd9;
      b1.load_valid = (cyc < 5);
      b1.abort = (cyc == 5);
      e = sb.pop_front();
      o = obs1();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL hold_load cyc%0d: got out=%0d flags=%b, expected out=%0d flags=%b",
                 cyc, o.out, o[3:0], e.out, e[3:0]);
      end
      cyc++;
    end
    b1.abort = 1'b0;
    $display("held load on dut1 (4 then 9), aborted: out=%0d", b1.out);
  endtask

  task automatic test_prescale_abort();
    smp_t e, o;
    int   cyc = 0;
    b4.load_value = 8'd2; b4.load_valid = 1'b1; b4.reload_en = 1'b0; b4.abort = 1'b0;
    for (int j = 0; j < 8; j++) sb.push_back(mk(2, 0, 1, 0, 0));
    for (int j = 8; j < 16; j++) sb.push_back(mk(1, 0, 1, 0, 0));
    sb.push_back(mk(0, 1, 0, 1, 1));
    sb.push_back(mk(0, 0, 0, 1, 1));
    for (int j = 0; j < 18; j++) begin
      b4.active = (j >= 2) && (j % 2 == 0);
      step();
      b4.load_valid = 1'b0;
      e = sb.pop_front();
      o = obs4();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL prescale_toggle cyc%0d: got out=%0d flags=%b, expected out=%0d flags=%b",
                 j, o.out, o[3:0], e.out, e[3:0]);
      end
    end
    $display("load 2 on dut4, active toggling: out=%0d done=%0b", b4.out, b4.done);
    b4.load_value = 8'd10; b4.load_valid = 1'b1; b4.active = 1'b1;
    for (int j = 0; j < 4; j++) sb.push_back(mk(10, 0, 1, 0, 0));
    sb.push_back(mk(9, 0, 1, 0, 0));
    sb.push_back(mk(9, 0, 1, 0, 0));
    sb.push_back(mk(0, 0, 0, 0, 1));
    sb.push_back(mk(0, 0, 0, 0, 1));
    while (sb.size() > 0) begin
      step();
      b4.load_valid = 1'b0;
      b4.abort = (cyc == 5);
      e = sb.pop_front();
      o = obs4();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL prescale_abort cyc%0d: got out=%0d flags=%b, expected out=%0d flags=%b",
                 cyc, o.out, o[3:0], e.out, e[3:0]);
      end
      cyc++;
    end
    b4.abort = 1'b0;
    $display("load 10 on dut4, aborted mid-run: out=%0d busy=%0b", b4.out, b4.busy);
  endtask

  initial begin
    rst = 1'b1;
    b1.load_valid = 1'b0; b1.load_value = '0; b1.reload_en = 1'b0; b1.active = 1'b0; b1.abort = 1'b0;
    b4.load_valid = 1'b0; b4.load_value = '0; b4.reload_en = 1'b0; b4.active = 1'b0; b4.abort = 1'b0;
    test_reset();
    test_reset_mid_count();
    test_count_down();
    test_reload_abort();
    test_zero_and_max();
    test_hold_load();
    test_prescale_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
